chess_cursor_input: RTL and testbench

//  Input front end for the chess engine. It synchronises and debounces the four

---
 rtl/chess_cursor_input.sv | 198 +++++++++++++++++++
 tb/tb_chess_cursor_input.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_cursor_input.sv
// Chess board input front end: synchronises and debounces the keys and lock switch, moves the cursor, and offers moves over valid/ready.
// Optional auto-repeat of a held direction key is built when CURSOR_AUTOREPEAT_EN is defined.
module chess_cursor_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 7500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       KeyLeft,
    input  logic       KeyUp,
    input  logic       KeyDown,
    input  logic       KeyRight,
    input  logic       LockSwitch,
    output logic [2:0] cursorX,
    output logic [2:0] cursorY,
    output logic       selValid,
    output logic [5:0] selSquare,
    output logic       moveValid,
    output logic [5:0] moveFrom,
    output logic [5:0] moveTo,
    input  logic       moveReady
);

    localparam int unsigned NUM_IN = 5;
    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 || DEBOUNCE_CYCLES < 2) begin : gBadParams
        $error("chess_cursor_input: DEBOUNCE_CYCLES/REPEAT_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
    end

    typedef enum logic [1:0] {SEL_FROM, SEL_TO, OFFER} stateT;

    // Index 0 is the lock switch; 4:1 are {left, up, down, right}, all active-high internally
    logic [NUM_IN-1:0]    rawActive;
    logic [NUM_IN-1:0]    syncMeta;
    logic [NUM_IN-1:0]    syncOut;
    logic [NUM_IN-1:0]    stable;
    logic [NUM_IN-1:0]    stableDly;
    logic [NUM_IN-1:0]    pressPulse;
    logic [CNT_WIDTH-1:0] debCnt [NUM_IN];
    logic [3:0]           keyPulse;
    logic [3:0]           movePulse;
    logic                 lockPulse;
    logic [5:0]           cursorSquare;

    stateT      state, stateNext;
    logic       selValidNext, moveValidNext;
    logic [5:0] selSquareNext, moveFromNext, moveToNext;

    assign rawActive    = {~KeyLeft, ~KeyUp, ~KeyDown, ~KeyRight, LockSwitch};
    assign keyPulse     = pressPulse[4:1];
    assign lockPulse    = pressPulse[0];
    assign cursorSquare = {cursorY, cursorX};

    // Two-flop synchroniser, debounce counter and rising-edge pulse per input
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            syncMeta   <= '0;
            syncOut    <= '0;
            stable     <= '0;
            stableDly  <= '0;
            pressPulse <= '0;
            for (int i = 0; i < NUM_IN; i++) debCnt[i] <= '0;
        end else begin
            syncMeta   <= rawActive;
            syncOut    <= syncMeta;
            stableDly  <= stable;
            pressPulse <= stable & ~stableDly;
            for (int i = 0; i < NUM_IN; i++) begin
                if (syncOut[i] == stable[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == DEB_LAST) begin
                    stable[i] <= ~stable[i];
                    debCnt[i] <= '0;
                end else begin
                    debCnt[i] <= debCnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int unsigned RPT_WIDTH = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RPT_WIDTH-1:0] rptCnt;
    logic                 rptActive;
    logic [3:0]           rptPulse;
    logic                 dirOneHot;

    assign dirOneHot = $onehot(stable[4:1]);
    assign movePulse = keyPulse | rptPulse;

    // Repeat is armed only by a press that leaves exactly one key down; any other key state disarms it
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rptCnt    <= '0;
            rptActive <= 1'b0;
            rptPulse  <= '0;
        end else begin
            rptPulse <= '0;
            if ((|keyPulse) && dirOneHot) begin
                rptActive <= 1'b1;
                rptCnt    <= RPT_WIDTH'(REPEAT_DELAY - 2);
            end else if (!dirOneHot) begin
                rptActive <= 1'b0;
            end else if (rptActive) begin
                if (rptCnt == '0) begin
                    rptPulse <= stable[4:1];
                    rptCnt   <= RPT_WIDTH'(REPEAT_PERIOD - 1);
                end else begin
                    rptCnt <= rptCnt - RPT_WIDTH'(1);
                end
            end
        end
    end
`else
    assign movePulse = keyPulse;
`endif

    // Cursor wraps mod 8; opposing pulses in the same cycle cancel
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cursorX <= '0;
            cursorY <= '0;
        end else begin
            if (movePulse[3] && !movePulse[0])      cursorX <= cursorX - 3'd1;
            else if (movePulse[0] && !movePulse[3]) cursorX <= cursorX + 3'd1;
            if (movePulse[2] && !movePulse[1])      cursorY <= cursorY - 3'd1;
            else if (movePulse[1] && !movePulse[2]) cursorY <= cursorY + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= SEL_FROM;
            selValid  <= 1'b0;
            selSquare <= '0;
            moveValid <= 1'b0;
            moveFrom  <= '0;
            moveTo    <= '0;
        end else begin
            state     <= stateNext;
            selValid  <= selValidNext;
            selSquare <= selSquareNext;
            moveValid <= moveValidNext;
            moveFrom  <= moveFromNext;
            moveTo    <= moveToNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            SEL_FROM: if (lockPulse) stateNext = SEL_TO;
            SEL_TO:   if (lockPulse) stateNext = (cursorSquare == selSquare) ? SEL_FROM : OFFER;
            OFFER:    if (moveValid && moveReady) stateNext = SEL_FROM;
            default:  stateNext = SEL_FROM;
        endcase
    end

    // Lock pulses in OFFER fall through untouched, so they are dropped
    always_comb begin
        selValidNext  = selValid;
        selSquareNext = selSquare;
        moveValidNext = moveValid;
        moveFromNext  = moveFrom;
        moveToNext    = moveTo;
        case (state)
            SEL_FROM: begin
                if (lockPulse) begin
                    selValidNext  = 1'b1;
                    selSquareNext = cursorSquare;
                end
            end
            SEL_TO: begin
                if (lockPulse) begin
                    if (cursorSquare == selSquare) begin
                        selValidNext = 1'b0;
                    end else begin
                        moveFromNext  = selSquare;
                        moveToNext    = cursorSquare;
                        moveValidNext = 1'b1;
                    end
                end
            end
            OFFER: begin
                if (moveValid && moveReady) begin
                    moveValidNext = 1'b0;
                    selValidNext  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chess_cursor_input.sv
// Scoreboard bench for chess_cursor_input: every output change is popped against the next expected snapshot and its cycle.
// Build with or without CURSOR_AUTOREPEAT_EN; the expected repeat moves follow the macro.
module tb_chess_cursor_input;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       KeyLeft, KeyUp, KeyDown, KeyRight, LockSwitch, moveReady;
    logic [2:0] cursorX, cursorY;
    logic       selValid, moveValid;
    logic [5:0] selSquare, moveFrom, moveTo;

    chess_cursor_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .KeyLeft   (KeyLeft),
        .KeyUp     (KeyUp),
        .KeyDown   (KeyDown),
        .KeyRight  (KeyRight),
        .LockSwitch(LockSwitch),
        .cursorX   (cursorX),
        .cursorY   (cursorY),
        .selValid  (selValid),
        .selSquare (selSquare),
        .moveValid (moveValid),
        .moveFrom  (moveFrom),
        .moveTo    (moveTo),
        .moveReady (moveReady)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [25:0] expQ[$];
    int          cycQ[$];
    logic        monOn = 1'b0;
    logic [25:0] lastOut;
    logic [25:0] curOut;

    // Reference model of the outputs and of the selection state (0 from, 1 to, 2 offer)
    logic [2:0] mX, mY;
    logic       mSelV, mMv;
    logic [5:0] mSel, mFrom, mTo;
    int         mState;

    function automatic logic [25:0] dutOut();
        return {cursorX, cursorY, selValid, selSquare, moveValid, moveFrom, moveTo};
    endfunction

    function automatic logic [25:0] modelOut();
        return {mX, mY, mSelV, mSel, mMv, mFrom, mTo};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pushExp(input int when);
        expQ.push_back(modelOut());
        cycQ.push_back(when);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clock);
        checkVal("drain", expQ.size(), 0);
        if (expQ.size() != 0) begin
            expQ.delete();
            cycQ.delete();
        end
    endtask

    // Output monitor: each observed change must be the next queued snapshot at its cycle
    always @(negedge clock) begin
        if (monOn) begin
            curOut = dutOut();
            if (curOut !== lastOut) begin
                if (expQ.size() == 0) begin
                    checkVal("unexpected_change", curOut, lastOut);
                end else begin
                    checkVal("outputs", curOut, expQ.pop_front());
                    checkVal("latency", cyc, cycQ.pop_front());
                end
                lastOut = curOut;
            end
        end
    end

    task automatic stepCursor(input logic [3:0] keys, output logic moved);
        moved = 1'b0;
        if (keys[3] ^ keys[0]) begin
            mX    = keys[0] ? mX + 3'd1 : mX - 3'd1;
            moved = 1'b1;
        end
        if (keys[2] ^ keys[1]) begin
            mY    = keys[1] ? mY + 3'd1 : mY - 3'd1;
            moved = 1'b1;
        end
    endtask

    // keys = {left, up, down, right}; a steady change shows on the outputs 8 bench cycles after driving
    task automatic pressKeys(input logic [3:0] keys, input int hold);
        int   c;
        logic moved;
        @(negedge clock);
        {KeyLeft, KeyUp, KeyDown, KeyRight} = ~keys;
        c = cyc;
        stepCursor(keys, moved);
        if (moved) pushExp(c + 8);
`ifdef CURSOR_AUTOREPEAT_EN
        if ($onehot(keys)) begin
            for (int j = 0; 21 + 8 * j <= hold; j++) begin
                stepCursor(keys, moved);
                pushExp(c + 28 + 8 * j);
            end
        end
`endif
        tick(hold);
        {KeyLeft, KeyUp, KeyDown, KeyRight} = 4'b1111;
        tick(12);
        waitDrain();
    endtask

    task automatic lockSet(input logic v);
        int   c;
        logic rising;
        @(negedge clock);
        rising     = v && !LockSwitch;
        LockSwitch = v;
        c          = cyc;
        if (rising) begin
            case (mState)
                0: begin
                    mSel   = {mY, mX};
                    mSelV  = 1'b1;
                    mState = 1;
                    pushExp(c + 8);
                end
                1: begin
                    if ({mY, mX} == mSel) begin
                        mSelV  = 1'b0;
                        mState = 0;
                        pushExp(c + 8);
                    end else begin
                        mFrom  = mSel;
                        mTo    = {mY, mX};
                        mMv    = 1'b1;
                        mState = 2;
                        pushExp(c + 8);
                        if (moveReady) begin
                            mMv    = 1'b0;
                            mSelV  = 1'b0;
                            mState = 0;
                            pushExp(c + 9);
                        end
                    end
                end
                default: ;
            endcase
        end
        tick(12);
        waitDrain();
    endtask

    task automatic acceptMove();
        @(negedge clock);
        moveReady = 1'b1;
        mMv       = 1'b0;
        mSelV     = 1'b0;
        mState    = 0;
        pushExp(cyc + 1);
        @(negedge clock);
        moveReady = 1'b0;
        tick(3);
        waitDrain();
    endtask

    task automatic resetMid();
        @(negedge clock);
        reset_n = 1'b0;
        {mX, mY, mSelV, mSel, mMv, mFrom, mTo} = '0;
        mState = 0;
        pushExp(cyc + 1);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        waitDrain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        {KeyLeft, KeyUp, KeyDown, KeyRight} = 4'b1111;
        LockSwitch = 1'b0;
        moveReady  = 1'b0;
        {mX, mY, mSelV, mSel, mMv, mFrom, mTo} = '0;
        mState = 0;
        tick(3);
        checkVal("rst_cursorX", cursorX, 0);
        checkVal("rst_cursorY", cursorY, 0);
        checkVal("rst_selValid", selValid, 0);
        checkVal("rst_moveValid", moveValid, 0);
        checkVal("rst_all", dutOut(), 0);
        reset_n = 1'b1;
        lastOut = dutOut();
        monOn   = 1'b1;

        // Glitch shorter than the debounce window, then a clean press
        KeyRight = 1'b0;
        tick(3);
        KeyRight = 1'b1;
        tick(20);
        pressKeys(4'b0001, 10);

        // Wrap in both directions and same-cycle cancel
        pressKeys(4'b1000, 10);
        pressKeys(4'b1000, 10);
        pressKeys(4'b0001, 10);
        for (int i = 0; i < 8; i++) pressKeys(4'b0001, 10);
        checkVal("wrap_x", cursorX, 0);
        pressKeys(4'b0100, 10);
        checkVal("wrap_y", cursorY, 7);
        pressKeys(4'b1001, 10);
        pressKeys(4'b0110, 10);

        // Full move from (1,6) to (1,4), held while moveReady is low
        pressKeys(4'b0001, 10);
        pressKeys(4'b0100, 10);
        lockSet(1'b1);
        pressKeys(4'b0100, 10);
        pressKeys(4'b0100, 10);
        lockSet(1'b0);
        lockSet(1'b1);
        checkVal("offer_from", moveFrom, 6'o61);
        checkVal("offer_to", moveTo, 6'o41);
        tick(5);
        checkVal("offer_held_valid", moveValid, 1);
        checkVal("offer_held_from", moveFrom, 6'o61);
        acceptMove();

        // Cancel by locking the same square, then locks ignored during OFFER
        pressKeys(4'b0001, 10);
        pressKeys(4'b0001, 10);
        pressKeys(4'b0100, 10);
        lockSet(1'b0);
        lockSet(1'b1);
        lockSet(1'b0);
        lockSet(1'b1);
        checkVal("cancel_selValid", selValid, 0);
        checkVal("cancel_moveValid", moveValid, 0);
        lockSet(1'b0);
        lockSet(1'b1);
        pressKeys(4'b0001, 10);
        lockSet(1'b0);
        lockSet(1'b1);
        checkVal("offer2_to", moveTo, 6'o34);
        lockSet(1'b0);
        lockSet(1'b1);
        lockSet(1'b0);

        // Reset in the middle of an offer
        resetMid();

        // moveReady already high when the offer appears
        @(negedge clock);
        moveReady = 1'b1;
        lockSet(1'b1);
        lockSet(1'b0);
        pressKeys(4'b0001, 10);
        lockSet(1'b1);
        lockSet(1'b0);
        @(negedge clock);
        moveReady = 1'b0;

        // Held Down key from y=0
        pressKeys(4'b0010, 40);
`ifdef CURSOR_AUTOREPEAT_EN
        checkVal("repeat_y", cursorY, 4);
`else
        checkVal("repeat_y", cursorY, 1);
`endif

        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
